// File: rtl/fixed_to_bcd_display_converter.sv
// rtl/fixed_to_bcd_display_converter.sv - signed fixed-point to sign + 8-digit BCD converter (double-dabble)
module fixed_to_bcd_display_converter #(
  parameter int INT_BITS  = 16,
  parameter int FRAC_BITS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [INT_BITS+FRAC_BITS-1:0] value_in,
  output logic                          busy,
  output logic                          done,
  output logic                          neg_sign,
  output logic                          ovf,
  output logic [3:0]                    bcd_thousand,
  output logic [3:0]                    bcd_hundred,
  output logic [3:0]                    bcd_ten,
  output logic [3:0]                    bcd_one,
  output logic [3:0]                    bcd_tenth,
  output logic [3:0]                    bcd_centi,
  output logic [3:0]                    bcd_milli,
  output logic [3:0]                    bcd_tenth_milli
);

  localparam int W    = INT_BITS + FRAC_BITS;
  localparam int IACC = 20;  // five BCD digits for the integer part
  localparam int FACC = 16;  // four BCD digits for the scaled fraction
  localparam int PW   = FRAC_BITS + 14;
  localparam int CW   = $clog2(INT_BITS + 1);
  localparam logic [PW-1:0] TEN_K = PW'(10000);

  typedef enum logic [1:0] {S_IDLE, S_ABS, S_CONV, S_DONE} state_t;

  state_t                   state;
  logic [W-1:0]             val_q;
  logic                     sign_q;
  logic [IACC+INT_BITS-1:0] int_sr;
  logic [FACC+INT_BITS-1:0] frac_sr;
  logic [CW-1:0]            cnt;
  logic                     lost_q;  // a set bit fell off the top of the integer accumulator

  logic [W:0]               sext;
  logic [W:0]               mag;
  logic [INT_BITS-1:0]      int_part;
  logic [PW-1:0]            frac_prod;
  logic [13:0]              frac_scaled;
  logic [IACC-1:0]          int_adj;
  logic [19:0]              frac_adj;
  logic [IACC+INT_BITS-1:0] int_next;
  logic [FACC+INT_BITS-1:0] frac_next;
  logic [IACC-1:0]          int_acc;
  logic [FACC-1:0]          frac_acc;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [19:0] add3(input logic [19:0] a);
    logic [19:0] r;
    r = a;
    for (int i = 0; i < 5; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Magnitude at width+1 so the most-negative input does not wrap; fraction scaled to 0..9999.
  always_comb begin
    sext        = {val_q[W-1], val_q};
    mag         = val_q[W-1] ? (~sext + 1'b1) : sext;
    int_part    = mag[FRAC_BITS +: INT_BITS];
    frac_prod   = {14'd0, mag[FRAC_BITS-1:0]} * TEN_K;
    frac_scaled = frac_prod[FRAC_BITS +: 14];
  end

  // One double-dabble step for both accumulators.
  always_comb begin
    int_acc   = int_sr[INT_BITS +: IACC];
    frac_acc  = frac_sr[INT_BITS +: FACC];
    int_adj   = add3(int_acc);
    frac_adj  = add3({4'd0, frac_acc});
    int_next  = {int_adj, int_sr[INT_BITS-1:0]} << 1;
    frac_next = {frac_adj[FACC-1:0], frac_sr[INT_BITS-1:0]} << 1;
  end

  // Sequencer: capture, absolute value, INT_BITS shift steps, then publish the digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      val_q           <= '0;
      sign_q          <= 1'b0;
      int_sr          <= '0;
      frac_sr         <= '0;
      cnt             <= '0;
      lost_q          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      neg_sign        <= 1'b0;
      ovf             <= 1'b0;
      bcd_thousand    <= 4'd0;
      bcd_hundred     <= 4'd0;
      bcd_ten         <= 4'd0;
      bcd_one         <= 4'd0;
      bcd_tenth       <= 4'd0;
      bcd_centi       <= 4'd0;
      bcd_milli       <= 4'd0;
      bcd_tenth_milli <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            val_q <= value_in;
            busy  <= 1'b1;
            state <= S_ABS;
          end
        end
        S_ABS: begin
          sign_q  <= val_q[W-1];
          int_sr  <= {{IACC{1'b0}}, int_part};
          frac_sr <= {{FACC{1'b0}}, INT_BITS'(frac_scaled)};
          cnt     <= CW'(INT_BITS);
          lost_q  <= 1'b0;
          state   <= S_CONV;
        end
        S_CONV: begin
          int_sr  <= int_next;
          frac_sr <= frac_next;
          lost_q  <= lost_q | int_adj[IACC-1];
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_DONE;
        end
        S_DONE: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          neg_sign <= sign_q;
          if (lost_q || (int_acc[19:16] != 4'd0)) begin
            ovf             <= 1'b1;
            bcd_thousand    <= 4'd9;
            bcd_hundred     <= 4'd9;
            bcd_ten         <= 4'd9;
            bcd_one         <= 4'd9;
            bcd_tenth       <= 4'd9;
            bcd_centi       <= 4'd9;
            bcd_milli       <= 4'd9;
            bcd_tenth_milli <= 4'd9;
          end else begin
            ovf             <= 1'b0;
            bcd_thousand    <= int_acc[15:12];
            bcd_hundred     <= int_acc[11:8];
            bcd_ten         <= int_acc[7:4];
            bcd_one         <= int_acc[3:0];
            bcd_tenth       <= frac_acc[15:12];
            bcd_centi       <= frac_acc[11:8];
            bcd_milli       <= frac_acc[7:4];
            bcd_tenth_milli <= frac_acc[3:0];
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_bcd_display_converter.sv
// tb/tb_fixed_to_bcd_display_converter.sv - scoreboard bench for fixed_to_bcd_display_converter
module tb_fixed_to_bcd_display_converter;

  localparam int IB  = 16;
  localparam int FB  = 16;
  localparam int LAT = IB + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] value_in;
  logic        busy, done, neg_sign, ovf;
  logic [3:0]  d_th, d_hu, d_te, d_on, d_t1, d_t2, d_t3, d_t4;

  fixed_to_bcd_display_converter #(.INT_BITS(IB), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst(rst), .start(start), .value_in(value_in),
    .busy(busy), .done(done), .neg_sign(neg_sign), .ovf(ovf),
    .bcd_thousand(d_th), .bcd_hundred(d_hu), .bcd_ten(d_te), .bcd_one(d_on),
    .bcd_tenth(d_t1), .bcd_centi(d_t2), .bcd_milli(d_t3), .bcd_tenth_milli(d_t4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        neg;
    logic        ovf;
    logic [31:0] dig;
    logic [31:0] k;
  } exp_t;

  exp_t        q[$];
  logic        neg_last = 1'b0;
  logic        ovf_last = 1'b0;
  logic [31:0] dig_last = '0;
  int          errors = 0;
  int          checks = 0;
  int          accepts = 0;
  int          dones = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain decimal arithmetic on the signed value.
  function automatic exp_t model(input logic [31:0] v, input int k);
    exp_t   e;
    longint s, m, ip, fr;
    s = longint'($signed(v));
    m = (s < 0) ? -s : s;
    ip = m / 65536;
    fr = ((m % 65536) * 10000) / 65536;
    e.neg = (s < 0);
    e.k = 32'(k);
    if (ip >= 10000) begin
      e.ovf = 1'b1;
      e.dig = 32'h9999_9999;
    end else begin
      e.ovf = 1'b0;
      e.dig = {4'(ip / 1000), 4'((ip / 100) % 10), 4'((ip / 10) % 10), 4'(ip % 10),
               4'(fr / 1000), 4'((fr / 100) % 10), 4'((fr / 10) % 10), 4'(fr % 10)};
    end
    return e;
  endfunction

  // Monitor: pop and compare on every done, otherwise outputs must hold.
  always @(negedge clk) begin
    logic [31:0] dig_now;
    exp_t e;
    dig_now = {d_th, d_hu, d_te, d_on, d_t1, d_t2, d_t3, d_t4};
    if (!rst) begin
      if (done) begin
        dones++;
        if (q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("latency", 64'(cyc - int'(e.k)), 64'(LAT));
          check("digits", 64'(dig_now), 64'(e.dig));
          check("neg_sign", 64'(neg_sign), 64'(e.neg));
          check("ovf", 64'(ovf), 64'(e.ovf));
          check("busy_at_done", 64'(busy), 64'd0);
          dig_last = e.dig;
          neg_last = e.neg;
          ovf_last = e.ovf;
        end
      end else begin
        check("hold_outputs", {30'd0, neg_sign, ovf, dig_now}, {30'd0, neg_last, ovf_last, dig_last});
      end
    end
  end

  // Drive one cycle of start; record the expectation only if the DUT is idle.
  task automatic pulse(input logic [31:0] v, input logic s);
    @(negedge clk);
    start = s;
    value_in = v;
    if (s && !busy && !rst) begin
      q.push_back(model(v, cyc + 1));
      accepts++;
    end
  endtask

  task automatic wait_idle();
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("done_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_value();
    logic [31:0] v;
    case ($urandom_range(0, 2))
      0: v = $urandom;
      1: v = {$urandom_range(0, 12000) & 32'hFFFF, 16'h0} | 32'($urandom_range(0, 65535));
      default: v = 32'($urandom_range(0, 65535));
    endcase
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  logic [31:0] directed [8] = '{32'h0003_8000, 32'hFFFE_C000, 32'h0000_FFFF, 32'h04D2_915B,
                                32'h2710_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h270F_FFFF};

  initial begin
    rst = 1'b1;
    start = 1'b0;
    value_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_state", {busy, done, neg_sign, ovf, d_th, d_hu, d_te, d_on, d_t1, d_t2, d_t3, d_t4}, 36'd0);

    foreach (directed[i]) begin
      pulse(directed[i], 1'b1);
      wait_idle();
    end

    // Abort mid-conversion with reset; no done may follow.
    pulse(32'h0012_3456, 1'b1);
    pulse(32'h0, 1'b0);
    check("busy_after_start", 64'(busy), 64'd1);
    repeat (3) pulse(32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    accepts--;
    dig_last = '0;
    neg_last = 1'b0;
    ovf_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_abort", {busy, done, neg_sign, ovf, d_th, d_hu, d_te, d_on, d_t1, d_t2, d_t3, d_t4}, 36'd0);
    repeat (25) @(negedge clk);
    pulse(32'hFFFE_C000, 1'b1);
    wait_idle();

    // Start held high continuously: one done per accepted start.
    for (int i = 0; i < 60; i++) pulse(rand_value(), 1'b1);
    wait_idle();

    // Random values with random gaps.
    for (int i = 0; i < 40; i++) begin
      pulse(rand_value(), 1'b1);
      repeat ($urandom_range(0, 22)) pulse(rand_value(), 1'b0);
    end
    wait_idle();

    check("done_count", 64'(dones), 64'(accepts));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fixed_to_bcd_display_converter.md
Name: fixed_to_bcd_display_converter

Overview:
- Sits directly downstream of the 3-variable LU equation solver core.
- Takes one signed Q16.16 fixed-point result (X0/X1/X2, chosen by the solver's disp_control mux) and converts it sequentially into a sign flag plus 8 BCD digits: 4 integer, 4 fractional.
- The BCD digits feed the existing per-digit hex-to-seven-segment decoders (thousand .. tenth_milli).
- Uses a start/busy/done handshake and double-dabble conversion, so no wide combinational divider is needed.

Parameters:
- INT_BITS, 16, integer bits of the input format; must be >= 14; sets the shift count.
- FRAC_BITS, 16, fractional bits of the input format.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- value_in  input  INT_BITS+FRAC_BITS  signed two's-complement fixed-point value
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when the digit outputs are updated
- neg_sign  output  1  1 when value_in was negative
- ovf  output  1  1 when |integer part| >= 10000
- bcd_thousand, bcd_hundred, bcd_ten, bcd_one  output  4 each  integer digits
- bcd_tenth, bcd_centi, bcd_milli, bcd_tenth_milli  output  4 each  fractional digits

Behaviour:
- Reset: synchronous, active-high. All outputs go to 0 and the state goes to IDLE. A reset in any state, including mid-conversion, aborts the conversion with no done pulse.
- States: IDLE -> ABS -> CONV -> DONE -> IDLE.
- IDLE:
  - If start=1, capture value_in and go to ABS.
  - Otherwise hold.
  - start asserted in any other state is ignored and is not queued.
- ABS (1 cycle):
  - sign = value_in MSB.
  - mag = two's-complement absolute value, computed at width+1 so that the most-negative input yields 2^(INT_BITS+FRAC_BITS-1) without wrapping.
  - int_part = mag >> FRAC_BITS.
  - frac_scaled = (mag[FRAC_BITS-1:0] * 10000) >> FRAC_BITS, truncated with no rounding; range 0..9999.
  - Clear the BCD accumulators and load a shift counter with INT_BITS.
- CONV (exactly INT_BITS cycles):
  - Run double-dabble in parallel on int_part (5-digit accumulator) and frac_scaled (zero-padded to INT_BITS, 4-digit accumulator).
  - Each cycle, first add 3 to every BCD nibble that is >= 5, then shift left one bit.
  - After the final shift, go to DONE.
- DONE (1 cycle):
  - Register the digit outputs, neg_sign and ovf; done=1, busy=0.
  - Next state is IDLE.
- Overflow: ovf=1 when the ten-thousands accumulator digit is non-zero. All 8 output digits are then forced to 9 (display 9999.9999); neg_sign still reflects the input sign.
- Latency: start sampled at edge k -> outputs and done update at edge k+INT_BITS+2 (k+18 at defaults). busy is high from edge k+1 until that edge.
- Outputs hold their last result between conversions; they change only on a DONE cycle or on reset.
- neg_sign follows the input sign even when every displayed digit is 0 (e.g. -0.00001 displays -0000.0000).
- start in the DONE cycle is ignored; a new start is accepted from the following IDLE cycle, giving back-to-back throughput of one result per INT_BITS+3 cycles.

Test Plan:
- rst=1 for 2 cycles mid-conversion, with start pulsed 5 cycles earlier -> no done pulse; all outputs 0; busy=0; the next start converts normally.
- value_in=0x00038000 (3.5) -> done exactly 18 cycles after start is sampled; neg_sign=0, digits 0,0,0,3 . 5,0,0,0; ovf=0.
- value_in=0xFFFEC000 (-1.25) -> neg_sign=1, digits 0001.2500. Then value_in=0x0000FFFF -> 0000.9999, truncated with no round-up.
- value_in=0x04D2915B (1234 + 37211/65536) -> digits 1234.5677, confirming truncation.
- value_in=0x27100000 (10000.0) -> ovf=1, digits 9999.9999, neg_sign=0. value_in=0x80000000 -> ovf=1, neg_sign=1, digits all 9.
- Pulse start on every cycle while busy -> exactly one done per accepted start; the second conversion begins in the IDLE cycle after DONE; the first result holds until the second done.
